// File: rtl/branch_predictor_pkg.sv
// Shared pipeline constants for the branch predictor slice.
// Holds the EX-stage BRANCH opcode, the EX_correct resolution encodings,
// the 2-bit counter state names and the counter power-up value.
package branch_predictor_pkg;

   // EX-stage opcode that marks a resolving conditional branch
   localparam logic [3:0] OP_BRANCH = 4'b0010;

   // EX_correct encodings: bit 1 set means the prediction was right
   localparam logic [1:0] EXC_TAKEN_WRONG     = 2'b00;
   localparam logic [1:0] EXC_NOT_TAKEN_WRONG = 2'b01;
   localparam logic [1:0] EXC_CORRECT         = 2'b10;
   localparam int         EXC_CORRECT_BIT     = 1;

   // Two-bit saturating counter states; the MSB is the taken/not-taken vote
   typedef enum logic [1:0] {
      CTR_STRONG_NT = 2'b00,
      CTR_WEAK_NT   = 2'b01,
      CTR_WEAK_T    = 2'b10,
      CTR_STRONG_T  = 2'b11
   } ctr_state_t;

   // Counters wake up leaning not-taken so a cold entry needs one taken to flip
   localparam ctr_state_t CTR_RESET = CTR_WEAK_NT;

   // A resolution is a mispredict whenever the "correct" bit is clear
   function automatic logic isMispredict(input logic [1:0] correct);
      return !correct[EXC_CORRECT_BIT];
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: one 2-bit saturating up/down counter, one per BHT entry.
// Resets asynchronously to weakly-not-taken and only moves when enabled.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       up,
   output logic [1:0] count
);

   ctr_state_t state;

   // Step one state toward taken (up=1) or not-taken (up=0), pinning at the
   // strong ends so a long run of one outcome cannot wrap the vote around.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= CTR_RESET;
      end else if (en) begin
         case (state)
            CTR_STRONG_NT: state <= up ? CTR_WEAK_NT  : CTR_STRONG_NT;
            CTR_WEAK_NT:   state <= up ? CTR_WEAK_T   : CTR_STRONG_NT;
            CTR_WEAK_T:    state <= up ? CTR_STRONG_T : CTR_WEAK_NT;
            default:       state <= up ? CTR_STRONG_T : CTR_WEAK_T;
         endcase
      end
   end

   assign count = state;

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: tagged, direct-mapped branch history/target table.
// Fetch looks up IF_PC combinationally; EX-stage BRANCH resolutions train the
// counters, install targets and count mispredicts.
// Optional feature macro: BP_GSHARE_EN -- XORs a global outcome history into
// the counter index (tags, valid bits and targets stay PC-indexed).
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int DBITS          = 32,
   parameter int BHT_INDEX_BITS = 4
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DBITS-1:0]          IF_PC,
   output logic                      prediction,
   output logic [DBITS-1:0]          predTarget,
   output logic [BHT_INDEX_BITS-1:0] predHist,
   input  logic [3:0]                EX_opcode,
   input  logic [DBITS-1:0]          EX_PC,
   input  logic                      EX_condFlag,
   input  logic [1:0]                EX_correct,
   input  logic [BHT_INDEX_BITS-1:0] EX_hist,
   input  logic [DBITS-1:0]          imm,
   output logic [15:0]               missCount
);

   localparam int ENTRIES  = 1 << BHT_INDEX_BITS;
   localparam int TAG_BITS = DBITS - BHT_INDEX_BITS - 2;
   localparam int IDX_HI   = BHT_INDEX_BITS + 1;

   logic [ENTRIES-1:0]        validVec;
   logic [TAG_BITS-1:0]       tagArr    [ENTRIES];
   logic [DBITS-1:0]          targetArr [ENTRIES];
   logic [1:0]                ctrArr    [ENTRIES];
   logic [15:0]               missReg;

   logic [BHT_INDEX_BITS-1:0] fetchIdx;
   logic [BHT_INDEX_BITS-1:0] fetchCtrIdx;
   logic [TAG_BITS-1:0]       fetchTag;
   logic                      fetchHit;

   logic [DBITS-1:0]          updPc;
   logic [BHT_INDEX_BITS-1:0] updIdx;
   logic [BHT_INDEX_BITS-1:0] updCtrIdx;
   logic [TAG_BITS-1:0]       updTag;
   logic                      updHit;
   logic                      updEn;
   logic                      unusedBits;

   // EX_PC arrives as PC+4 of the branch, so step back one word to find the
   // entry the branch itself was fetched from.
   assign updPc    = EX_PC - DBITS'(4);
   assign updIdx   = updPc[IDX_HI:2];
   assign updTag   = updPc[DBITS-1:IDX_HI+1];
   assign updEn    = (EX_opcode == OP_BRANCH);
   assign updHit   = validVec[updIdx] && (tagArr[updIdx] == updTag);

   assign fetchIdx = IF_PC[IDX_HI:2];
   assign fetchTag = IF_PC[DBITS-1:IDX_HI+1];
   assign fetchHit = validVec[fetchIdx] && (tagArr[fetchIdx] == fetchTag);

`ifdef BP_GSHARE_EN
   logic [BHT_INDEX_BITS-1:0] histReg;

   // Global history: shift each resolved outcome in at the LSB so the newest
   // branch always sits in bit 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         histReg <= '0;
      end else if (updEn) begin
         histReg <= {histReg[BHT_INDEX_BITS-2:0], EX_condFlag};
      end
   end

   assign fetchCtrIdx = fetchIdx ^ histReg;
   assign updCtrIdx   = updIdx ^ EX_hist;
   assign predHist    = histReg;
   assign unusedBits  = ^{IF_PC[1:0], updPc[1:0]};
`else
   assign fetchCtrIdx = fetchIdx;
   assign updCtrIdx   = updIdx;
   assign predHist    = '0;
   assign unusedBits  = ^{IF_PC[1:0], updPc[1:0], EX_hist};
`endif

   // Lookup is purely combinational off the current table contents, so a
   // same-cycle update to the same slot is only seen on the following cycle.
   assign prediction = fetchHit && ctrArr[fetchCtrIdx][1];
   assign predTarget = prediction ? targetArr[fetchIdx] : (IF_PC + DBITS'(4));
   assign missCount  = missReg;

   // One counter per entry. A taken outcome always trains its counter; a
   // not-taken outcome only trains it when the PC entry really belongs to
   // this branch, so unrelated aliasing branches cannot erode it.
   for (genvar g = 0; g < ENTRIES; g++) begin : gCounters
      logic ctrEn;
      assign ctrEn = updEn && (updCtrIdx == BHT_INDEX_BITS'(g)) && (EX_condFlag || updHit);
      sat_counter2 uCounter (
         .clk   (clk),
         .reset (reset),
         .en    (ctrEn),
         .up    (EX_condFlag),
         .count (ctrArr[g])
      );
   end

   // Tag/target store: only taken branches allocate, because only they have
   // a target worth redirecting fetch to. Not-taken resolutions leave the
   // stored target alone so a later re-taken branch still finds it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         validVec <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tagArr[i]    <= '0;
            targetArr[i] <= '0;
         end
      end else if (updEn && EX_condFlag) begin
         validVec[updIdx]  <= 1'b1;
         tagArr[updIdx]    <= updTag;
         targetArr[updIdx] <= updPc + imm;
      end
   end

   // Mispredict statistic: counts every resolved BRANCH whose resolution code
   // says the guess was wrong, and sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         missReg <= '0;
      end else if (updEn && isMispredict(EX_correct) && (missReg != 16'hFFFF)) begin
         missReg <= missReg + 16'd1;
      end
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter DBITS, default 32, the datapath and PC width.
REQ-002 SHALL have parameter BHT_INDEX_BITS, default 4, the log2 table depth (16 entries).
REQ-003 SHALL have a single clock and an asynchronous active-high reset: clk input 1, the sole clock, rising edge; reset input 1, asynchronous, active-high.
REQ-004 SHALL have these ports:
- IF_PC  input  DBITS  fetch-stage PC to predict.
- prediction  output  1  1 = predicted taken.
- predTarget  output  DBITS  next fetch PC.
- predHist  output  BHT_INDEX_BITS  history snapshot, carried down the pipeline with the branch.
- EX_opcode  input  4  EX-stage opcode; update only when equal to 4'b0010 (BRANCH).
- EX_PC  input  DBITS  PC+4 of the resolving branch.
- EX_condFlag  input  1  actual outcome, 1 = taken.
- EX_correct  input  2  resolution code: 2'b1x correct, 2'b00 taken-not-supposed-to, 2'b01 not-taken-supposed-to.
- EX_hist  input  BHT_INDEX_BITS  predHist value returned from EX.
- imm  input  DBITS  branch offset.
- missCount  output  16  resolved-mispredict count.

Function
REQ-005 SHALL hold 2^BHT_INDEX_BITS entries, each with a 2-bit saturating counter, a valid bit, a tag and a DBITS target.
REQ-006 SHALL use fetch index IF_PC[BHT_INDEX_BITS+1:2] and tag IF_PC[DBITS-1:BHT_INDEX_BITS+2].
REQ-007 SHALL make the lookup combinational in the same cycle: hit = valid && tag match; prediction = hit && counter[1].
REQ-008 SHALL drive predTarget = stored target when prediction = 1, else IF_PC + 4, with modulo-2^DBITS wrap.
REQ-009 SHALL update the tables at the rising clk edge only when EX_opcode == 4'b0010; any other opcode leaves all state unchanged.
REQ-010 SHALL use update PC = EX_PC - 4; its index and tag SHALL be derived as in REQ-006.
REQ-011 SHALL increment the counter when EX_condFlag = 1 and decrement it when EX_condFlag = 0, saturating at 2'b11 and 2'b00.
REQ-012 SHALL, when EX_condFlag = 1, write target = EX_PC - 4 + imm, set valid = 1 and write the tag.
REQ-013 SHALL, when EX_condFlag = 0 and the entry misses on tag, leave the entry untouched.
REQ-014 SHALL increment missCount when an update occurs with EX_correct[1] = 0, saturating at 16'hFFFF.
REQ-015 SHALL, when a read and an update hit the same index in the same cycle, return the pre-update value; there is no bypass.
REQ-016 SHALL treat an EX_correct value inconsistent with EX_condFlag as legal: tables follow EX_condFlag and missCount follows EX_correct.

Reset
REQ-017 SHALL, while reset = 1, asynchronously set every counter to 2'b01 (weakly not taken), clear every valid bit, and clear missCount and the history register to 0.
REQ-018 SHALL produce prediction = 0 and predTarget = IF_PC + 4 while reset is asserted and in the first cycle after it.
REQ-019 SHALL discard an update coincident with reset assertion.

Configuration
REQ-020 SHALL, with BP_GSHARE_EN defined, keep a BHT_INDEX_BITS global history register that shifts in EX_condFlag on each update, LSB newest.
REQ-021 SHALL, with BP_GSHARE_EN defined, index counters by (PC index XOR history) at fetch and (PC index XOR EX_hist) at update; valid, tag and target SHALL stay PC-indexed; predHist = history register.
REQ-022 SHALL, without BP_GSHARE_EN, hold predHist at 0, ignore EX_hist and use no history register.

Structure
REQ-023 SHALL place the BRANCH opcode constant, the EX_correct encodings and the counter reset value 2'b01 in the shared pipeline package.
REQ-024 SHALL implement one sub-module, sat_counter2: a 2-bit saturating up/down counter with asynchronous reset to 2'b01, instantiated per entry.

Verification
REQ-025 SHALL cover: reset, then IF_PC=0x40 -> prediction=0, predTarget=0x44, missCount=0.
REQ-026 SHALL cover: two BRANCH updates, EX_PC=0x44, imm=0x20, condFlag=1, correct=01 then 10; then IF_PC=0x40 -> prediction=1, predTarget=0x60, missCount=1.
REQ-027 SHALL cover: the entry from REQ-026, then three updates with condFlag=0 -> counter 00, prediction=0, target retained.
REQ-028 SHALL cover: IF_PC=0x440, same index as 0x40 but a different tag, after REQ-026 -> prediction=0, predTarget=0x444.
REQ-029 SHALL cover: a same-cycle read and update of index 0 -> old counter observed, new counter observed the next cycle; EX_opcode=4'b0000 with condFlag=1 -> no state change.
REQ-030 SHALL cover: with missCount=16'hFFFF and a further mispredict -> missCount stays 16'hFFFF; reset asserted mid-run -> all state cleared before the next edge.
